// File: rtl/store_rmw_ctrl_pkg.sv
// Shared encodings for the store read-modify-write controller.
// The alignment fault check is compiled in with STORE_ALIGN_CHECK_EN.
package store_pkg;

  typedef enum logic [1:0] {
    OP_SW  = 2'b00,
    OP_SH  = 2'b01,
    OP_SB  = 2'b10,
    OP_RSV = 2'b11
  } store_op_e;

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_READ  = 2'b01,
    S_WRITE = 2'b10,
    S_DONE  = 2'b11
  } state_e;

  localparam int MAX_RD_LAT = 4;
  localparam int CNT_W      = $clog2(MAX_RD_LAT + 1);

  // sw must be word aligned, sh halfword aligned; sb can never fault.
  function automatic logic is_misaligned(store_op_e op, logic [1:0] lane);
    return ((op == OP_SW) && (lane != 2'b00)) || ((op == OP_SH) && lane[0]);
  endfunction

endpackage

// File: rtl/store_rmw_ctrl_if.sv
// Request and data-memory port bundle between the control unit, the store
// controller (slave) and the word-addressed data memory.
interface store_rmw_ctrl_if;
  import store_pkg::*;

  logic        start;
  store_op_e   store_op;
  logic [31:0] addr;
  logic [31:0] store_data;
  logic [31:0] mem_rdata;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_wr;
  logic        busy;
  logic        done;
  logic        misaligned;

  modport master (
    output start, store_op, addr, store_data, mem_rdata,
    input  mem_addr, mem_wdata, mem_wr, busy, done, misaligned
  );

  modport slave (
    input  start, store_op, addr, store_data, mem_rdata,
    output mem_addr, mem_wdata, mem_wr, busy, done, misaligned
  );

endinterface

// File: rtl/store_rmw_ctrl_byte_merge.sv
// Combinational little-endian lane merge of store data into an existing word.
module byte_merge
  import store_pkg::*;
(
  input  store_op_e   op,
  input  logic [1:0]  lane_sel,
  input  logic [31:0] old_word,
  input  logic [31:0] store_data,
  output logic [31:0] merged
);

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      localparam logic HI_HALF = (gi >= 2);
      logic sel_b;
      logic sel_h;

      assign sel_b = (op == OP_SB) && (lane_sel == 2'(gi));
      // addr[0] is ignored for halfwords: both lanes of the selected half are written.
      assign sel_h = (op == OP_SH) && (lane_sel[1] == HI_HALF);

      assign merged[8*gi +: 8] = (op == OP_SW) ? store_data[8*gi +: 8] :
                                 sel_b         ? store_data[7:0] :
                                 sel_h         ? store_data[8*(gi%2) +: 8] :
                                                 old_word[8*gi +: 8];
    end
  endgenerate

endmodule

// File: rtl/store_rmw_ctrl.sv
// Store controller: sw writes directly, sh/sb read the target word, merge and write back.
// Optional alignment fault detection is enabled with STORE_ALIGN_CHECK_EN.
module store_rmw_ctrl
  import store_pkg::*;
#(
  parameter int MEM_RD_LAT = 1
)
(
  input  logic              clk,
  input  logic              reset,
  store_rmw_ctrl_if.slave   bus
);

  state_e            state_reg, state_next;
  logic [CNT_W-1:0]  cnt_reg, cnt_next;
  store_op_e         op_reg, op_next;
  logic [1:0]        lane_reg, lane_next;
  logic [31:0]       data_reg, data_next;
  logic [31:0]       mem_addr_reg, mem_addr_next;
  logic [31:0]       mem_wdata_reg, mem_wdata_next;
  logic              mem_wr_reg, mem_wr_next;
  logic              busy_reg, busy_next;
  logic              done_reg, done_next;
  logic              mis_reg, mis_next;
  logic              fault;
  logic [31:0]       merged;

  byte_merge u_merge (
    .op         (op_reg),
    .lane_sel   (lane_reg),
    .old_word   (bus.mem_rdata),
    .store_data (data_reg),
    .merged     (merged)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= S_IDLE;
      cnt_reg       <= '0;
      op_reg        <= OP_SW;
      lane_reg      <= 2'b00;
      data_reg      <= '0;
      mem_addr_reg  <= '0;
      mem_wdata_reg <= '0;
      mem_wr_reg    <= 1'b0;
      busy_reg      <= 1'b0;
      done_reg      <= 1'b0;
      mis_reg       <= 1'b0;
    end else begin
      state_reg     <= state_next;
      cnt_reg       <= cnt_next;
      op_reg        <= op_next;
      lane_reg      <= lane_next;
      data_reg      <= data_next;
      mem_addr_reg  <= mem_addr_next;
      mem_wdata_reg <= mem_wdata_next;
      mem_wr_reg    <= mem_wr_next;
      busy_reg      <= busy_next;
      done_reg      <= done_next;
      mis_reg       <= mis_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    cnt_next       = cnt_reg;
    op_next        = op_reg;
    lane_next      = lane_reg;
    data_next      = data_reg;
    mem_addr_next  = mem_addr_reg;
    mem_wdata_next = mem_wdata_reg;
    mis_next       = 1'b0;
    fault          = 1'b0;
`ifdef STORE_ALIGN_CHECK_EN
    fault          = is_misaligned(bus.store_op, bus.addr[1:0]);
`endif

    case (state_reg)
      S_IDLE: begin
        if (bus.start) begin
          op_next   = bus.store_op;
          lane_next = bus.addr[1:0];
          data_next = bus.store_data;
          cnt_next  = '0;
          if ((bus.store_op == OP_RSV) || fault) begin
            state_next = S_DONE;
            mis_next   = fault;
          end else begin
            mem_addr_next = {bus.addr[31:2], 2'b00};
            if (bus.store_op == OP_SW) begin
              state_next     = S_WRITE;
              mem_wdata_next = bus.store_data;
            end else begin
              state_next = S_READ;
            end
          end
        end
      end
      S_READ: begin
        // Read data is valid in the last READ cycle; merge straight into the write register.
        if (cnt_reg == CNT_W'(MEM_RD_LAT)) begin
          state_next     = S_WRITE;
          mem_wdata_next = merged;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      S_WRITE: state_next = S_DONE;
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase

    mem_wr_next = (state_next == S_WRITE);
    busy_next   = (state_next != S_IDLE);
    done_next   = (state_next == S_DONE);
  end

  assign bus.mem_addr   = mem_addr_reg;
  assign bus.mem_wdata  = mem_wdata_reg;
  assign bus.mem_wr     = mem_wr_reg;
  assign bus.busy       = busy_reg;
  assign bus.done       = done_reg;
  assign bus.misaligned = mis_reg;

endmodule

// File: doc/store_rmw_ctrl.md
Name: store_rmw_ctrl

Overview:
Memory-side counterpart of the register write-data path. It takes a store (sw/sh/sb) from the multicycle control unit and drives the data memory write port. Sub-word stores use a read-modify-write sequence so that untouched bytes of the target word are preserved. It sits between register B / ALUOut and the word-addressed data memory.

Parameters:
MEM_RD_LAT, 1, cycles from presenting mem_addr until mem_rdata is valid (range 1..4).

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
start  in  1  one-cycle request; sampled only in IDLE
store_op  in  2  00=sw, 01=sh, 10=sb, 11=reserved
addr  in  32  byte address (ALUOut)
store_data  in  32  register B value
mem_rdata  in  32  memory read data
mem_addr  out  32  word address; bits[1:0] always 00
mem_wdata  out  32  memory write data
mem_wr  out  1  write strobe, one cycle per store
busy  out  1  high from the cycle after start until done
done  out  1  one-cycle completion pulse
misaligned  out  1  alignment fault pulse (feature only; tied 0 otherwise)

Behaviour:
- Clock and reset: single clock clk. reset is synchronous and active-high. All outputs are registered.
- Reset values: mem_addr=0, mem_wdata=0, mem_wr=0, busy=0, done=0, misaligned=0. State=IDLE.
- Latching: on start in IDLE, store_op, addr and store_data are latched. Input changes after that cycle are ignored. start while busy is ignored (no queueing).
- States: IDLE, READ, WRITE, DONE.
- sw: IDLE -> WRITE -> DONE -> IDLE.
  - Start in cycle 0. In cycle 1, mem_wr=1, mem_addr={addr[31:2],2'b00}, mem_wdata=store_data.
  - done=1 in cycle 2.
- sh/sb: IDLE -> READ -> WRITE -> DONE.
  - READ lasts MEM_RD_LAT+1 cycles with mem_addr driven and mem_wr=0.
  - mem_rdata is captured at the end of the last READ cycle.
  - WRITE in cycle MEM_RD_LAT+2 with merged data. done in cycle MEM_RD_LAT+3 (cycle 4 for LAT=1).
- Merge (little-endian lanes, lane k = bits[8k+7:8k]):
  - sb: lane addr[1:0] <- store_data[7:0]; other lanes from the captured word.
  - sh: lanes {2*addr[1]+1, 2*addr[1]} <- store_data[15:0]; addr[0] ignored.
- Reserved op 11: IDLE -> DONE. No memory access; done pulses in cycle 1.
- busy is high in every non-IDLE state, including DONE. busy=0 in the cycle after done.
- done pulses exactly once per accepted start.
- Reset mid-operation: state -> IDLE and all outputs -> reset values at that edge.
  - Reset during READ: no write is issued.
  - Reset coinciding with WRITE: mem_wr deasserts at that edge; the write that was already strobed is not undone.
- A start in the same cycle as done is ignored. A new start is accepted once busy=0.

Optional Feature:
STORE_ALIGN_CHECK_EN
- Defined: a store is faulted if it is sw with addr[1:0]!=0, or sh with addr[0]=1.
  - The fault is detected at start. FSM goes IDLE -> DONE with no memory access.
  - misaligned=1 and done=1 pulse together in cycle 1.
- Undefined: low address bits are ignored as described in Merge. misaligned is tied 0.

Decomposition:
- Shared package store_pkg holds:
  - op encodings OP_SW, OP_SH, OP_SB, OP_RSV
  - state encodings S_IDLE, S_READ, S_WRITE, S_DONE
  - read-latency counter width derived from max MEM_RD_LAT=4 (3 bits)
- One natural sub-module, byte_merge: purely combinational (op, addr[1:0], old word, store_data) -> merged word. It is unit-testable alone.

Test Plan:
- sw, addr=0x0000_0010, store_data=0xDEADBEEF -> mem_wr=1 in cycle 1 with mem_addr=0x10, mem_wdata=0xDEADBEEF; done in cycle 2.
- sb, addr=0x0000_0013, store_data=0x0000_00AB, mem_rdata=0x11223344, LAT=1 -> READ for cycles 1-2; WRITE in cycle 3 with mem_wdata=0xAB223344; done in cycle 4.
- sh, addr=0x0000_0022, store_data=0x0000_CAFE, mem_rdata=0x11223344 -> mem_wdata=0xCAFE3344, mem_addr=0x20. Repeat with MEM_RD_LAT=3: done in cycle 6.
- reset asserted in cycle 2 of an sb -> mem_wr never asserts, busy=0 and done=0 at the next edge; a start issued afterwards completes normally.
- start re-pulsed in cycles 1 and 2 of an sw -> exactly one write and one done; op 11 -> done in cycle 1 with no mem_wr.
- With STORE_ALIGN_CHECK_EN, sw at addr=0x0000_0006 -> misaligned=1 and done=1 in cycle 1, no mem_wr. Without it, the same store writes mem_addr=0x4.
